// File: rtl/popcount_frame_acc.sv
// popcount_frame_acc: sums per-beat popcounts and beat counts over a frame into a one-entry output buffer
// Ports: CLK, ASYNCRESETN (async active-low); I_valid/I_ready/I_count/I_last input beat stream;
//        O_valid/O_ready handshake with O_sum, O_beats, O_sat (saturated), O_err (count > 8) frame result.
module popcount_frame_acc #(
  parameter int ACC_WIDTH = 12,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 I_valid,
  output logic                 I_ready,
  input  logic [3:0]           I_count,
  input  logic                 I_last,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic [ACC_WIDTH-1:0] O_sum,
  output logic [CNT_WIDTH-1:0] O_beats,
  output logic                 O_sat,
  output logic                 O_err
);
  logic                 r_first, r_sat, r_err, r_o_valid, r_o_sat, r_o_err;
  logic [ACC_WIDTH-1:0] r_acc, r_o_sum;
  logic [CNT_WIDTH-1:0] r_beats, r_o_beats;
  logic                 w_accept, w_sat_nx, w_err_nx;
  logic [ACC_WIDTH:0]   w_sum_ext;
  logic [CNT_WIDTH:0]   w_beats_ext;
  logic [ACC_WIDTH-1:0] w_acc_nx;
  logic [CNT_WIDTH-1:0] w_beats_nx;
  assign I_ready  = !r_o_valid || O_ready;
  assign w_accept = I_valid && I_ready;
  assign O_valid  = r_o_valid;
  assign O_sum    = r_o_sum;
  assign O_beats  = r_o_beats;
  assign O_sat    = r_o_sat;
  assign O_err    = r_o_err;
  // A new frame starts from zero, so the carry-out bit alone flags saturation.
  always_comb begin
    w_sum_ext   = (r_first ? '0 : {1'b0, r_acc}) + (ACC_WIDTH+1)'(I_count);
    w_beats_ext = (r_first ? '0 : {1'b0, r_beats}) + (CNT_WIDTH+1)'(1);
    w_acc_nx    = w_sum_ext[ACC_WIDTH] ? '1 : w_sum_ext[ACC_WIDTH-1:0];
    w_beats_nx  = w_beats_ext[CNT_WIDTH] ? '1 : w_beats_ext[CNT_WIDTH-1:0];
    w_sat_nx    = (!r_first && r_sat) || w_sum_ext[ACC_WIDTH] || w_beats_ext[CNT_WIDTH];
    w_err_nx    = (!r_first && r_err) || (I_count > 4'd8);
  end
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_first   <= 1'b1;
      r_acc     <= '0;
      r_beats   <= '0;
      r_sat     <= 1'b0;
      r_err     <= 1'b0;
      r_o_valid <= 1'b0;
      r_o_sum   <= '0;
      r_o_beats <= '0;
      r_o_sat   <= 1'b0;
      r_o_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_first <= I_last;
        r_acc   <= w_acc_nx;
        r_beats <= w_beats_nx;
        r_sat   <= w_sat_nx;
        r_err   <= w_err_nx;
      end
      // A last beat reloads the buffer even while the old result drains this cycle.
      if (w_accept && I_last) begin
        r_o_valid <= 1'b1;
        r_o_sum   <= w_acc_nx;
        r_o_beats <= w_beats_nx;
        r_o_sat   <= w_sat_nx;
        r_o_err   <= w_err_nx;
      end else if (O_ready) begin
        r_o_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_popcount_frame_acc.sv
// tb_popcount_frame_acc: scoreboard bench driving a default-width and a narrow-width instance in lockstep
module tb_popcount_frame_acc;
  localparam int AW0 = 12, CW0 = 10, AW1 = 4, CW1 = 3;
  typedef struct {int sum; int beats; bit sat; bit err;} res_t;
  logic CLK = 1'b0, ASYNCRESETN = 1'b1, I_valid = 1'b0, I_last = 1'b0, O_ready = 1'b1;
  logic [3:0] I_count = 4'd0;
  logic i_rdy0, o_valid0, o_sat0, o_err0, i_rdy1, o_valid1, o_sat1, o_err1;
  logic [AW0-1:0] o_sum0;
  logic [CW0-1:0] o_beats0;
  logic [AW1-1:0] o_sum1;
  logic [CW1-1:0] o_beats1;
  res_t q0[$], q1[$];
  int cur[$];
  int n_tests = 0, n_fail = 0, n_acc = 0, ordy_mode = 0;
  bit rdy_exp = 1'b1;
  popcount_frame_acc #(.ACC_WIDTH(AW0), .CNT_WIDTH(CW0)) dut0 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I_valid(I_valid), .I_ready(i_rdy0),
    .I_count(I_count), .I_last(I_last), .O_valid(o_valid0), .O_ready(O_ready),
    .O_sum(o_sum0), .O_beats(o_beats0), .O_sat(o_sat0), .O_err(o_err0));
  popcount_frame_acc #(.ACC_WIDTH(AW1), .CNT_WIDTH(CW1)) dut1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I_valid(I_valid), .I_ready(i_rdy1),
    .I_count(I_count), .I_last(I_last), .O_valid(o_valid1), .O_ready(O_ready),
    .O_sum(o_sum1), .O_beats(o_beats1), .O_sat(o_sat1), .O_err(o_err1));
  always #5 CLK = ~CLK;
  // Frame result from the list of accepted counts: clamp totals, flag overflow and illegal counts.
  function automatic res_t model(int aw, int cw);
    res_t r;
    int tot = 0, smax = (1 << aw) - 1, bmax = (1 << cw) - 1;
    r.err = 1'b0;
    foreach (cur[i]) begin
      tot += cur[i];
      if (cur[i] > 8) r.err = 1'b1;
    end
    r.sum   = tot > smax ? smax : tot;
    r.beats = cur.size() > bmax ? bmax : cur.size();
    r.sat   = (tot > smax) || (cur.size() > bmax);
    return r;
  endfunction
  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge CLK) begin
    #1;
    O_ready = ordy_mode == 0 ? 1'b1 : ordy_mode == 1 ? 1'b0 : ($urandom_range(0, 2) != 0);
  end
  // Output monitor: handshake prediction, held-result comparison, pop on consumer accept.
  always @(negedge CLK) begin
    rdy_exp = (q0.size() == 0) || O_ready;
    chk("i_ready0", int'(i_rdy0), int'(rdy_exp));
    chk("i_ready1", int'(i_rdy1), int'(rdy_exp));
    chk("o_valid0", int'(o_valid0), int'(q0.size() != 0));
    chk("o_valid1", int'(o_valid1), int'(q1.size() != 0));
    if (o_valid0 && q0.size() != 0) begin
      chk("sum0", int'(o_sum0), q0[0].sum);
      chk("beats0", int'(o_beats0), q0[0].beats);
      chk("sat0", int'(o_sat0), int'(q0[0].sat));
      chk("err0", int'(o_err0), int'(q0[0].err));
      if (O_ready) void'(q0.pop_front());
    end
    if (o_valid1 && q1.size() != 0) begin
      chk("sum1", int'(o_sum1), q1[0].sum);
      chk("beats1", int'(o_beats1), q1[0].beats);
      chk("sat1", int'(o_sat1), int'(q1[0].sat));
      chk("err1", int'(o_err1), int'(q1[0].err));
      if (O_ready) void'(q1.pop_front());
    end
  end
  // Input monitor: records accepted beats and pushes the expected result when a frame closes.
  always @(negedge CLK) begin
    #1;
    if (ASYNCRESETN && I_valid && rdy_exp) begin
      cur.push_back(int'(I_count));
      n_acc++;
      if (I_last) begin
        q0.push_back(model(AW0, CW0));
        q1.push_back(model(AW1, CW1));
        cur.delete();
      end
    end
  end
  task automatic send(int c, bit l);
    int start = n_acc;
    I_valid = 1'b1;
    I_count = 4'(c);
    I_last  = l;
    for (int k = 0; k < 100 && n_acc == start; k++) begin
      @(posedge CLK);
      #1;
    end
    if (n_acc == start) chk("accept_timeout", 0, 1);
    I_valid = 1'b0;
  endtask
  task automatic idle(int n);
    I_valid = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic do_reset();
    #2;
    ASYNCRESETN = 1'b0;
    I_valid = 1'b0;
    cur.delete();
    q0.delete();
    q1.delete();
    #1;
    chk("rst_o_valid", int'(o_valid0) + int'(o_valid1), 0);
    chk("rst_o_sum", int'(o_sum0) + int'(o_sum1), 0);
    chk("rst_o_beats", int'(o_beats0) + int'(o_beats1), 0);
    chk("rst_flags", int'(o_sat0) + int'(o_err0) + int'(o_sat1) + int'(o_err1), 0);
    chk("rst_i_ready", int'(i_rdy0) + int'(i_rdy1), 2);
    @(posedge CLK);
    #3;
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    @(posedge CLK);
    #1;
    do_reset();
    send(3, 0); send(8, 0); send(0, 0); send(5, 1);
    idle(2);
    send(7, 1); send(2, 1);
    idle(2);
    ordy_mode = 1;
    send(4, 0); send(4, 1);
    fork
      begin
        repeat (5) @(posedge CLK);
        ordy_mode = 0;
      end
    join_none
    send(1, 0); send(1, 1);
    idle(2);
    send(8, 0); send(8, 1); send(1, 1);
    send(12, 0); send(1, 1);
    send(5, 0); send(5, 0);
    do_reset();
    send(2, 1);
    idle(2);
    for (int b = 0; b < 9; b++) send(1, b == 8);
    ordy_mode = 1;
    send(3, 1);
    idle(3);
    do_reset();
    ordy_mode = 2;
    for (int f = 0; f < 300; f++) begin
      int len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send($urandom_range(0, 9) == 9 ? $urandom_range(9, 15) : $urandom_range(0, 8), b == len - 1);
      end
      if ($urandom_range(0, 49) == 0) begin
        send($urandom_range(0, 8), 1'b0);
        do_reset();
      end
    end
    ordy_mode = 0;
    for (int k = 0; k < 50 && q0.size() != 0; k++) idle(1);
    idle(2);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/popcount_frame_acc.md
# popcount_frame_acc

Streaming accumulator downstream of the 8-bit population-count stage. Each beat carries one 4-bit popcount result (0..8) plus an end-of-frame marker. The block sums the counts and the number of beats over a frame, then presents the frame total on a one-entry valid/ready output buffer. It sits between the combinational popcount datapath and the frame-statistics consumer, and is the only registered element on that path.

## Interface
- `ACC_WIDTH`, default 12: width of the frame sum accumulator; saturates at 2^ACC_WIDTH−1.
- `CNT_WIDTH`, default 10: width of the beat counter; saturates at 2^CNT_WIDTH−1.

- `CLK` in 1: single clock; all state updates on the rising edge.
- `ASYNCRESETN` in 1: asynchronous, active-low reset.
- `I_valid` in 1: an input beat is present.
- `I_ready` out 1: the block accepts the beat this cycle.
- `I_count` in 4: popcount of one 8-bit word, legal range 0..8.
- `I_last` in 1: this beat closes the frame.
- `O_valid` out 1: a frame result is held.
- `O_ready` in 1: the consumer accepts the result.
- `O_sum` out ACC_WIDTH: sum of `I_count` over the frame.
- `O_beats` out CNT_WIDTH: number of beats in the frame, including the last beat.
- `O_sat` out 1: the sum or the beat counter saturated during the frame.
- `O_err` out 1: at least one beat in the frame had `I_count` > 8.

## Operation
- Input handshake: accept when `I_valid && I_ready`.
  - `I_ready = !O_valid || O_ready`, a combinational pass-through of the output stall.
- Internal state:
  - `acc`, `beats`, `sat`, `err` registers.
  - `first` flag: the next accepted beat starts a new frame.
- On an accepted beat with `first` = 1:
  - `acc ← I_count`, `beats ← 1`.
  - `sat ← 0`, `err ← (I_count > 8)`.
- On an accepted beat with `first` = 0:
  - `acc ← sat_add(acc, I_count)`, `beats ← sat_inc(beats)`.
  - `sat` and `err` are sticky-ORed with this beat's saturation and error conditions.
- Saturation:
  - Sum is computed at ACC_WIDTH+1 bits. If the result exceeds the maximum, clamp to all-ones and set `sat`.
  - Same rule for `beats`.
- Illegal counts (9..15) are still added as-is and set `err`. They are not clamped.
- Accepted beat with `I_last` = 1:
  - The final values, including this beat, load the output buffer (`O_sum`, `O_beats`, `O_sat`, `O_err`).
  - `O_valid ← 1`, `first ← 1`.
- Accepted beat with `I_last` = 0: `first ← 0`.
- Output handshake:
  - `O_valid && O_ready` clears `O_valid` next cycle, unless a new last beat is accepted in the same cycle. In that case the buffer reloads and `O_valid` stays 1.
- A single-beat frame (`first` = 1 and `I_last` = 1) yields `O_sum = I_count`, `O_beats = 1`.
- Output fields are stable while `O_valid && !O_ready`.
- Reset values:
  - `O_valid` = 0, `O_sum` = 0, `O_beats` = 0, `O_sat` = 0, `O_err` = 0.
  - `acc` = 0, `beats` = 0, `first` = 1.
  - `I_ready` = 1 immediately after reset, since `O_valid` = 0.
- Reset asserted mid-frame or mid-hold discards the partial frame and any held result. There is no recovery.

## Timing
- Latency: a last beat accepted at edge t gives `O_valid` = 1 and the result from t+1.
- Throughput: one beat per cycle with `O_ready` held high, including back-to-back single-beat frames.
- Backpressure: with `O_valid` = 1 and `O_ready` = 0, `I_ready` = 0. No beat is accepted, and accumulation of a frame already in progress freezes.
- Result drop and result duplication are forbidden.
- `I_count` and `I_last` are sampled only on accepted cycles. Beats with `I_valid` = 0 are ignored.
- `I_ready` has a combinational path from `O_ready` only, and no path from `I_valid`.

## Test plan
- Reset check: drive `ASYNCRESETN` = 0 between clock edges, then release. Outputs go to 0 immediately. `I_ready` = 1, `O_valid` = 0.
- Basic frame: counts 3, 8, 0, 5 with `I_last` on beat 4 and `O_ready` = 1. One cycle after beat 4 the outputs are `O_sum` = 16, `O_beats` = 4, `O_sat` = 0, `O_err` = 0.
- Back-to-back single-beat frames: count 7 then count 2, both with `I_last` = 1 and `O_ready` = 1. Results are `O_sum` = 7 then 2 on consecutive cycles, each with `O_beats` = 1.
- Backpressure:
  - Frame {4, 4 last}, then frame {1, 1 last}, with `O_ready` = 0 for 5 cycles.
  - `O_sum` = 8 stays held and `I_ready` = 0 throughout.
  - After `O_ready` goes high: 8 is accepted, then 2 follows. There is no loss and no repeat.
- Saturation: with `ACC_WIDTH` = 4, send counts 8, 8 with `I_last` on the second. Result is `O_sum` = 15, `O_sat` = 1. The next frame {1 last} gives `O_sum` = 1, `O_sat` = 0.
- Illegal count and mid-frame reset:
  - Frame {12, 1 last} gives `O_sum` = 13, `O_err` = 1.
  - Frame {5, 5} (no last), then reset, then {2 last}, gives `O_sum` = 2, `O_beats` = 1.
